// File: rtl/matmul_ext_port_ctrl.sv
// ============================================================================
// Module : matmul_ext_port_ctrl
// Desc   : Loads A/B BRAMs from a stream, runs the multiply, unloads C to a stream.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_ext_port_ctrl #(
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 8,
  parameter int AWIDTH       = 16,
  parameter int MASK_WIDTH   = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             go,
  input  logic [AWIDTH-1:0]                base_a,
  input  logic [AWIDTH-1:0]                base_b,
  input  logic [AWIDTH-1:0]                base_c,
  input  logic [AWIDTH-1:0]                stride,
  input  logic [3:0]                       num_rows,
  input  logic [15:0]                      wait_cycles,
  output logic                             busy,
  output logic                             done,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DWIDTH*MAT_MUL_SIZE-1:0]   in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DWIDTH*MAT_MUL_SIZE-1:0]   out_data,
  output logic                             out_last,
  output logic [AWIDTH-1:0]                bram_addr_a_ext,
  output logic [DWIDTH*MAT_MUL_SIZE-1:0]   bram_wdata_a_ext,
  output logic [MASK_WIDTH-1:0]            bram_we_a_ext,
  output logic [AWIDTH-1:0]                bram_addr_b_ext,
  output logic [DWIDTH*MAT_MUL_SIZE-1:0]   bram_wdata_b_ext,
  output logic [MASK_WIDTH-1:0]            bram_we_b_ext,
  output logic [AWIDTH-1:0]                bram_addr_c_ext,
  input  logic [DWIDTH*MAT_MUL_SIZE-1:0]   bram_rdata_c_ext,
  output logic [DWIDTH*MAT_MUL_SIZE-1:0]   bram_wdata_c_ext,
  output logic [MASK_WIDTH-1:0]            bram_we_c_ext,
  output logic                             start_reg,
  output logic                             clear_done_reg
);

  localparam int         DW   = DWIDTH * MAT_MUL_SIZE;
  localparam logic [3:0] MAXR = 4'(MAT_MUL_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_COMPUTE, S_UNLOAD, S_FINISH
  } state_t;

  state_t            state_q;
  logic              busy_q, done_q, in_ready_q, start_q, clr_q;
  logic [3:0]        rows_q, cnt_q, out_cnt_q;
  logic [AWIDTH-1:0] addr_q, base_b_q, base_c_q, stride_q;
  logic [15:0]       wait_q;
  logic [DW-1:0]     fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q, inflight_q;
  logic [1:0]        occ_q;

  logic       in_hs_d, hs_a_d, hs_b_d, pop_d, rd_en_d, ld_last_d;
  logic [1:0] credit_d;
  logic [3:0] rows_d;

  assign rows_d    = (num_rows == 4'd0 || num_rows > MAXR) ? MAXR : num_rows;
  assign in_hs_d   = in_valid & in_ready_q;
  assign hs_a_d    = in_hs_d & (state_q == S_LOAD_A);
  assign hs_b_d    = in_hs_d & (state_q == S_LOAD_B);
  assign ld_last_d = (cnt_q == rows_q - 4'd1);
  assign pop_d     = out_valid & out_ready;
  // A word leaving the FIFO this cycle frees its slot in time for a read issued now.
  assign credit_d  = occ_q + {1'b0, inflight_q} - {1'b0, pop_d};
  assign rd_en_d   = (state_q == S_UNLOAD) && (cnt_q != rows_q) && (credit_d < 2'd2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      clr_q      <= 1'b0;
      rows_q     <= 4'd0;
      cnt_q      <= 4'd0;
      out_cnt_q  <= 4'd0;
      addr_q     <= '0;
      base_b_q   <= '0;
      base_c_q   <= '0;
      stride_q   <= '0;
      wait_q     <= 16'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      inflight_q <= rd_en_d;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= bram_rdata_c_ext;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_d) begin
        rd_ptr_q  <= ~rd_ptr_q;
        out_cnt_q <= out_cnt_q + 4'd1;
      end
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop_d};

      case (state_q)
        S_IDLE: if (go) begin
          busy_q     <= 1'b1;
          in_ready_q <= 1'b1;
          addr_q     <= base_a;
          base_b_q   <= base_b;
          base_c_q   <= base_c;
          stride_q   <= stride;
          wait_q     <= wait_cycles;
          rows_q     <= rows_d;
          cnt_q      <= 4'd0;
          state_q    <= S_LOAD_A;
        end
        S_LOAD_A: if (in_hs_d) begin
          if (ld_last_d) begin
            cnt_q   <= 4'd0;
            addr_q  <= base_b_q;
            state_q <= S_LOAD_B;
          end else begin
            cnt_q  <= cnt_q + 4'd1;
            addr_q <= addr_q + stride_q;
          end
        end
        S_LOAD_B: if (in_hs_d) begin
          if (ld_last_d) begin
            cnt_q      <= 4'd0;
            in_ready_q <= 1'b0;
            start_q    <= 1'b1;
            state_q    <= S_START;
          end else begin
            cnt_q  <= cnt_q + 4'd1;
            addr_q <= addr_q + stride_q;
          end
        end
        S_START: begin
          start_q   <= 1'b0;
          cnt_q     <= 4'd0;
          out_cnt_q <= 4'd0;
          addr_q    <= base_c_q;
          state_q   <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (wait_q == 16'd0) begin
            clr_q   <= 1'b1;
            state_q <= S_UNLOAD;
          end else begin
            wait_q <= wait_q - 16'd1;
          end
        end
        S_UNLOAD: begin
          if (rd_en_d) begin
            cnt_q  <= cnt_q + 4'd1;
            addr_q <= addr_q + stride_q;
          end
          if (pop_d && out_last) begin
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          clr_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign in_ready         = in_ready_q;
  assign start_reg        = start_q;
  assign clear_done_reg   = clr_q;

  assign bram_addr_a_ext  = hs_a_d ? addr_q : '0;
  assign bram_wdata_a_ext = hs_a_d ? in_data : '0;
  assign bram_we_a_ext    = {MASK_WIDTH{hs_a_d}};
  assign bram_addr_b_ext  = hs_b_d ? addr_q : '0;
  assign bram_wdata_b_ext = hs_b_d ? in_data : '0;
  assign bram_we_b_ext    = {MASK_WIDTH{hs_b_d}};
  assign bram_addr_c_ext  = rd_en_d ? addr_q : '0;
  assign bram_wdata_c_ext = '0;
  assign bram_we_c_ext    = '0;

  assign out_valid        = (occ_q != 2'd0);
  assign out_data         = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign out_last         = out_valid && (out_cnt_q == rows_q - 4'd1);

endmodule

`default_nettype wire

// File: tb/tb_matmul_ext_port_ctrl.sv
// ============================================================================
// Module : tb_matmul_ext_port_ctrl
// Desc   : Scoreboard bench for matmul_ext_port_ctrl with a C-BRAM read model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_ext_port_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        go = 1'b0;
  logic [15:0] base_a = '0, base_b = '0, base_c = '0, stride = '0;
  logic [3:0]  num_rows = '0;
  logic [15:0] wait_cycles = '0;
  logic        busy, done, in_ready, out_valid, out_last, start_reg, clear_done_reg;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0, out_data;
  logic [15:0] bram_addr_a_ext, bram_addr_b_ext, bram_addr_c_ext;
  logic [63:0] bram_wdata_a_ext, bram_wdata_b_ext, bram_wdata_c_ext;
  logic [63:0] bram_rdata_c_ext = '0;
  logic [7:0]  bram_we_a_ext, bram_we_b_ext, bram_we_c_ext;

  int total = 0, bad = 0;
  int cyc = 0, done_cnt = 0, start_cnt = 0, hs_n = 0, first_cyc = 0, last_cyc = 0;
  logic [79:0] exp_wa[$], exp_wb[$];
  logic [64:0] exp_out[$];

  matmul_ext_port_ctrl dut (
    .clk(clk), .resetn(resetn), .go(go),
    .base_a(base_a), .base_b(base_b), .base_c(base_c), .stride(stride),
    .num_rows(num_rows), .wait_cycles(wait_cycles),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .bram_addr_a_ext(bram_addr_a_ext), .bram_wdata_a_ext(bram_wdata_a_ext), .bram_we_a_ext(bram_we_a_ext),
    .bram_addr_b_ext(bram_addr_b_ext), .bram_wdata_b_ext(bram_wdata_b_ext), .bram_we_b_ext(bram_we_b_ext),
    .bram_addr_c_ext(bram_addr_c_ext), .bram_rdata_c_ext(bram_rdata_c_ext),
    .bram_wdata_c_ext(bram_wdata_c_ext), .bram_we_c_ext(bram_we_c_ext),
    .start_reg(start_reg), .clear_done_reg(clear_done_reg)
  );

  initial forever #5 clk = ~clk;

  // C BRAM content is a fixed function of the address, so wrong addresses show up as wrong data.
  function automatic logic [63:0] cfun(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1234};
  endfunction

  always @(posedge clk) bram_rdata_c_ext <= cfun(bram_addr_c_ext);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [79:0] e;
    logic [64:0] eo;
    logic [63:0] prev_d;
    logic        prev_stall;
    prev_stall = 1'b0;
    prev_d     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        prev_stall = 1'b0;
        continue;
      end
      if (bram_we_a_ext != 8'h00) begin
        chk("wa_avail", 64'(exp_wa.size() != 0), 64'd1);
        chk("wa_we", 64'(bram_we_a_ext), 64'hFF);
        if (exp_wa.size() != 0) begin
          e = exp_wa.pop_front();
          chk("wa_addr", 64'(bram_addr_a_ext), 64'(e[79:64]));
          chk("wa_data", bram_wdata_a_ext, e[63:0]);
        end
      end
      if (bram_we_b_ext != 8'h00) begin
        chk("wb_avail", 64'(exp_wb.size() != 0), 64'd1);
        chk("wb_we", 64'(bram_we_b_ext), 64'hFF);
        if (exp_wb.size() != 0) begin
          e = exp_wb.pop_front();
          chk("wb_addr", 64'(bram_addr_b_ext), 64'(e[79:64]));
          chk("wb_data", bram_wdata_b_ext, e[63:0]);
        end
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", out_data, prev_d);
      end
      if (out_valid && out_ready) begin
        chk("out_avail", 64'(exp_out.size() != 0), 64'd1);
        if (exp_out.size() != 0) begin
          eo = exp_out.pop_front();
          chk("out_data", out_data, eo[63:0]);
          chk("out_last", 64'(out_last), 64'(eo[64]));
        end
        if (hs_n == 0) first_cyc = cyc;
        last_cyc = cyc;
        hs_n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      if (start_reg) start_cnt++;
      if (done) done_cnt++;
    end
  endtask

  task automatic run(input logic [3:0] nr, input logic [15:0] ba, input logic [15:0] bb,
                     input logic [15:0] bc, input logic [15:0] st, input logic [15:0] wc,
                     input bit stall, input bit dup_go, input bit pat, input bit kill);
    int          n, k, g, d0, s0;
    bit          hs, dup_done;
    logic [63:0] w [16];
    logic [3:0]  k4;
    logic [15:0] a;
    n = (nr == 4'd0 || nr > 4'd8) ? 8 : int'(nr);
    for (int i = 0; i < 2 * n; i++) begin
      k4   = 4'(i + 1);
      w[i] = pat ? {16{k4}} : {$urandom(), $urandom()};
    end
    for (int r = 0; r < n; r++) begin
      a = ba + 16'(r) * st; exp_wa.push_back({a, w[r]});
      a = bb + 16'(r) * st; exp_wb.push_back({a, w[n + r]});
      a = bc + 16'(r) * st;
      if (!kill) exp_out.push_back({(r == n - 1), cfun(a)});
    end
    hs_n = 0; d0 = done_cnt; s0 = start_cnt;
    out_ready = !stall;
    @(posedge clk); #1;
    go = 1'b1; base_a = ba; base_b = bb; base_c = bc; stride = st;
    num_rows = nr; wait_cycles = wc;
    @(posedge clk); #1;
    go = 1'b0;
    base_a = 16'($urandom()); base_b = 16'($urandom()); base_c = 16'($urandom());
    stride = 16'($urandom()); num_rows = 4'($urandom()); wait_cycles = 16'($urandom());
    chk("busy_go", 64'(busy), 64'd1);
    in_valid = 1'b1; in_data = w[0];
    k = 0; g = 0; dup_done = 1'b0;
    while (k < 2 * n && g < 2000) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      go = (dup_go && !dup_done && k == 1);
      if (go) dup_done = 1'b1;
      if (k < 2 * n) begin
        if ($urandom_range(3) == 0) in_valid = 1'b0;
        else begin in_valid = 1'b1; in_data = w[k]; end
      end
      g++;
    end
    go = 1'b0;
    chk("feed", 64'(k), 64'(2 * n));
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0BAD_F00D;
    if (kill) begin
      g = 0;
      while (start_cnt == s0 && g < 200) begin @(posedge clk); #1; g++; end
      chk("kill_start", 64'(start_cnt - s0), 64'd1);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      chk("kill_ctl", 64'({busy, done, in_ready, out_valid, out_last, start_reg, clear_done_reg}), 64'd0);
      chk("kill_addr", 64'({bram_addr_a_ext, bram_addr_b_ext, bram_addr_c_ext}), 64'd0);
      chk("kill_wd", bram_wdata_a_ext | bram_wdata_b_ext | bram_wdata_c_ext | out_data, 64'd0);
      chk("kill_we", 64'({bram_we_a_ext, bram_we_b_ext, bram_we_c_ext}), 64'd0);
      in_valid = 1'b0;
      exp_out.delete();
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("kill_nodone", 64'(done_cnt - d0), 64'd0);
      return;
    end
    if (stall) begin
      g = 0;
      while (!clear_done_reg && g < 5000) begin @(posedge clk); #1; g++; end
      chk("unload_seen", 64'(clear_done_reg), 64'd1);
      repeat (10) @(posedge clk);
      #1;
    end
    g = 0;
    while (done_cnt == d0 && g < 5000) begin
      @(posedge clk); #1;
      if (stall) out_ready = ~out_ready;
      g++;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("done_n", 64'(done_cnt - d0), 64'd1);
    chk("start_n", 64'(start_cnt - s0), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("out_count", 64'(hs_n), 64'(n));
    chk("out_left", 64'(exp_out.size()), 64'd0);
    chk("wr_left", 64'(exp_wa.size() + exp_wb.size()), 64'd0);
    if (!stall) chk("b2b", 64'(last_cyc - first_cyc), 64'(n - 1));
  endtask

  initial begin
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({busy, done, in_ready, out_valid, out_last, start_reg, clear_done_reg}), 64'd0);
    chk("rst_addr", 64'({bram_addr_a_ext, bram_addr_b_ext, bram_addr_c_ext}), 64'd0);
    chk("rst_wd", bram_wdata_a_ext | bram_wdata_b_ext | bram_wdata_c_ext | out_data, 64'd0);
    chk("rst_we", 64'({bram_we_a_ext, bram_we_b_ext, bram_we_c_ext}), 64'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    run(4'd2,  16'h0000, 16'h0100, 16'h0200, 16'd8, 16'd20, 0, 0, 1, 0);
    run(4'd0,  16'h1000, 16'h2000, 16'h3000, 16'd3, 16'd5,  0, 0, 0, 0);
    run(4'd5,  16'h0040, 16'h0080, 16'h00C0, 16'd4, 16'd0,  1, 0, 0, 0);
    run(4'd2,  16'h0000, 16'h0010, 16'hFFF8, 16'd8, 16'd3,  0, 0, 0, 0);
    run(4'd3,  16'h0500, 16'h0600, 16'h0700, 16'd2, 16'd7,  0, 1, 0, 0);
    run(4'd4,  16'h0900, 16'h0A00, 16'h0B00, 16'd1, 16'd200, 0, 0, 0, 1);
    run(4'd12, 16'hC000, 16'hD000, 16'hE000, 16'h11, 16'd2, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
